memory_loader: RTL and testbench
================================

# memory_loader

Input staging block for the MAC/TPU datapath. Serially loads a 4x4 feature matrix and a 4x4 weight matrix, one 8-bit element per clock, into two independent 16-entry on-chip memories in row-major order. It also exposes both memories through a combinational read port for the downstream systolic feeder. It sits between the external byte-wide load ports and the MAC array.

## Interface
- DATA_W, 8, element width in bits (elements treated as raw bytes; sign interpretation is downstream)
- DEPTH, 16, entries per memory (4x4 matrix, row-major)
- ADDR_W, 4, log2(DEPTH)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- port_A  input  DATA_W  feature element to write
- port_W  input  DATA_W  weight element to write
- write_enable_A  input  1  write port_A into Feature_Memory this cycle
- write_enable_W  input  1  write port_W into Weight_Memory this cycle
- rd_addr  input  ADDR_W  read index, shared by both memories
- rd_data_A  output  DATA_W  Feature_Memory[rd_addr]
- rd_data_W  output  DATA_W  Weight_Memory[rd_addr]
- count_A  output  ADDR_W+1  number of feature elements loaded (0..DEPTH)
- count_W  output  ADDR_W+1  number of weight elements loaded (0..DEPTH)
- full_A  output  1  count_A == DEPTH
- full_W  output  1  count_W == DEPTH

## Operation
- Storage arrays are named Feature_Memory and Weight_Memory, DEPTH x DATA_W each. Benches read them hierarchically, so the names are mandatory.
- Each memory has a private write pointer, which is the low ADDR_W bits of its count.
- When write_enable_X=1 and full_X=0 on a rising edge:
  - Memory[ptr] <= port_X
  - count_X increments by 1
- Element k of the stream lands at index k (row = k/4, col = k%4).
- When full_X=1, writes are ignored: no wrap-around, no overwrite, and count stays at DEPTH. Only reset rearms loading.
- Feature and weight channels are fully independent. Simultaneous writes to both in one cycle are legal and both complete.
- Deasserting write_enable pauses the pointer. Loading resumes at the next index when enable is reasserted; gaps do not advance the pointer.
- Read paths are combinational and have no enable.

## Timing
- Reset (rst=0) takes effect immediately, independent of clk:
  - all Feature_Memory and Weight_Memory entries become 0
  - count_A = count_W = 0, full_A = full_W = 0
  - rd_data_A/W therefore read 0
- Reset release is synchronous in effect: the first write is captured at the first rising edge with rst=1.
- Reset asserted mid-load discards all loaded data and both pointers.
- Write latency: data and enable are sampled at a rising edge. The new entry, count and full are visible immediately after that edge.
- Read latency: 0 cycles (combinational from rd_addr and the array).
- Reading an index in the same cycle it is being written returns the old value until the edge.
- Loading 16 elements takes 16 consecutive enabled cycles. full_X rises right after the 16th edge.

## Structure
- Shared package (tpu_pkg): DATA_W, DEPTH, ADDR_W constants, reused by the MAC array and feeder.
- One natural sub-module, load_bank, containing:
  - a single DEPTH x DATA_W array
  - a write pointer/count
  - a full flag
  - a combinational read
- memory_loader instantiates load_bank twice (feature, weight). If hierarchy flattening is not used, each instance exposes its array so that Feature_Memory and Weight_Memory remain reachable at the memory_loader level.

## Test plan
- Reset: hold rst=0 for 2 cycles → all 32 entries 0, counts 0, full flags 0. Pulse rst=0 between edges → immediate clear.
- Weight load: write_enable_W=1 for 16 cycles with 4,0,2,1, 4,3,2,0, 4,3,0,1, 4,3,2,1 → Weight_Memory[0..15] holds those values in order, full_W=1, Feature_Memory still all 0.
- Feature load: write_enable_A=1 for 16 cycles with 1,2,3,4 repeated four times → Feature_Memory[i] = (i%4)+1, count_A=16.
- Overflow: a 17th feature write of 9 after full → Feature_Memory[0] stays 1, count_A stays 16.
- Concurrent/paused: both enables high with A=5, W=7; then one idle cycle; then A=6, W=8 → entries [0]=5/7 and [1]=6/8, counts 2.
- Mid-load reset: after 6 writes assert rst=0 → counts 0 and entries 0. The next write lands at index 0.
- Readback: after full loads, sweep rd_addr 0..15 → rd_data_A/W match the arrays in the same cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared datapath constants for the MAC/TPU blocks (loader,
//               systolic feeder, MAC array).
//               DATA_W - element width in bits (raw bytes)
//               DEPTH  - entries per 4x4 matrix memory, row-major
//               ADDR_W - index width for one matrix memory
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
endpackage
`default_nettype wire

// File: rtl/load_bank.sv
`default_nettype none
// ============================================================================
// Module      : load_bank
// Description : One serially loaded matrix memory. Each accepted write
//               stores wr_data at the next free index and advances the
//               count. Once all DEPTH entries are filled, further writes are
//               ignored until reset.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous reset, active-low
//               wr_en    - write wr_data this cycle
//               wr_data  - element to store
//               rd_addr  - combinational read index
//               rd_data  - mem[rd_addr]
//               count    - elements loaded (0..DEPTH)
//               full     - count == DEPTH
//               mem      - storage array, exported for the parent's view
// Revision    : 1.0 - initial release
// ============================================================================
module load_bank
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [DATA_W-1:0] mem [DEPTH]
);

  localparam logic [ADDR_W:0] c_full_count = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_one        = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] w_ptr;
  logic              w_full;

  // The write pointer is the count's low bits; the extra MSB only lets the
  // count reach DEPTH, and full blocks any write past that point.
  assign w_ptr  = r_count[ADDR_W-1:0];
  assign w_full = (r_count == c_full_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && !w_full) begin
      mem[w_ptr] <= wr_data;
      r_count    <= r_count + c_one;
    end
  end

  assign rd_data = mem[rd_addr];
  assign count   = r_count;
  assign full    = w_full;

endmodule
`default_nettype wire

// File: rtl/memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : memory_loader
// Description : Input staging for the MAC/TPU datapath. Loads a 4x4 feature
//               matrix and a 4x4 weight matrix, one byte per clock, into two
//               independent row-major memories. Both memories are read
//               combinationally through a shared read index.
// Ports       : clk            - rising-edge clock
//               rst            - asynchronous reset, active-low
//               port_A/port_W  - feature / weight element to write
//               write_enable_A - write port_A into Feature_Memory
//               write_enable_W - write port_W into Weight_Memory
//               rd_addr        - read index shared by both memories
//               rd_data_A/W    - Feature_Memory / Weight_Memory [rd_addr]
//               count_A/W      - elements loaded per channel (0..DEPTH)
//               full_A/W       - channel holds DEPTH elements
// Revision    : 1.0 - initial release
// ============================================================================
module memory_loader
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] port_A,
  input  logic [DATA_W-1:0] port_W,
  input  logic              write_enable_A,
  input  logic              write_enable_W,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_A,
  output logic [DATA_W-1:0] rd_data_W,
  output logic [ADDR_W:0]   count_A,
  output logic [ADDR_W:0]   count_W,
  output logic              full_A,
  output logic              full_W
);

  // Named at this level so the loaded matrices stay visible here even when
  // the hierarchy is not flattened.
  logic [DATA_W-1:0] Feature_Memory [DEPTH];
  logic [DATA_W-1:0] Weight_Memory  [DEPTH];

  load_bank u_feature_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (write_enable_A),
    .wr_data (port_A),
    .rd_addr (rd_addr),
    .rd_data (rd_data_A),
    .count   (count_A),
    .full    (full_A),
    .mem     (Feature_Memory)
  );

  load_bank u_weight_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (write_enable_W),
    .wr_data (port_W),
    .rd_addr (rd_addr),
    .rd_data (rd_data_W),
    .count   (count_W),
    .full    (full_W),
    .mem     (Weight_Memory)
  );

endmodule
`default_nettype wire

// File: tb/tb_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_loader
// Description : Scoreboard bench for memory_loader. Stimulus pushes expected
//               results into a queue; a monitor on the falling edge pops and
//               compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_loader;

  localparam int K_CNT = 0;  // counts and full flags
  localparam int K_MEM = 1;  // array entries at addr (hierarchical)
  localparam int K_RD  = 2;  // combinational read port at current rd_addr

  typedef struct {
    int         kind;
    int         addr;
    logic [7:0] ea;
    logic [7:0] ew;
    logic [4:0] eca;
    logic [4:0] ecw;
    logic       efa;
    logic       efw;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] port_A, port_W;
  logic       write_enable_A, write_enable_W;
  logic [3:0] rd_addr;
  logic [7:0] rd_data_A, rd_data_W;
  logic [4:0] count_A, count_W;
  logic       full_A, full_W;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] wv [16] = '{8'd4, 8'd0, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd0,
                          8'd4, 8'd3, 8'd0, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};

  memory_loader dut (
    .clk            (clk),
    .rst            (rst),
    .port_A         (port_A),
    .port_W         (port_W),
    .write_enable_A (write_enable_A),
    .write_enable_W (write_enable_W),
    .rd_addr        (rd_addr),
    .rd_data_A      (rd_data_A),
    .rd_data_W      (rd_data_W),
    .count_A        (count_A),
    .count_W        (count_W),
    .full_A         (full_A),
    .full_W         (full_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() != 0) begin
        e = q.pop_front();
        total++;
        case (e.kind)
          K_CNT: if ({count_A, count_W, full_A, full_W} !== {e.eca, e.ecw, e.efa, e.efw}) begin
            bad++;
            $display("FAIL %s: got cA=%0d cW=%0d fA=%0d fW=%0d want cA=%0d cW=%0d fA=%0d fW=%0d",
                     e.name, count_A, count_W, full_A, full_W, e.eca, e.ecw, e.efa, e.efw);
          end
          K_MEM: if ({dut.Feature_Memory[e.addr], dut.Weight_Memory[e.addr]} !== {e.ea, e.ew}) begin
            bad++;
            $display("FAIL %s[%0d]: got A=%0d W=%0d want A=%0d W=%0d", e.name, e.addr,
                     dut.Feature_Memory[e.addr], dut.Weight_Memory[e.addr], e.ea, e.ew);
          end
          default: if ({rd_data_A, rd_data_W} !== {e.ea, e.ew}) begin
            bad++;
            $display("FAIL %s[%0d]: got rdA=%0d rdW=%0d want rdA=%0d rdW=%0d", e.name, rd_addr,
                     rd_data_A, rd_data_W, e.ea, e.ew);
          end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_cnt(input int ca, input int cw, input bit fa, input bit fw, input string nm);
    exp_t e;
    e.kind = K_CNT; e.addr = 0; e.ea = '0; e.ew = '0;
    e.eca = 5'(ca); e.ecw = 5'(cw); e.efa = fa; e.efw = fw; e.name = nm;
    q.push_back(e);
  endtask

  task automatic push_mem(input int kind, input int addr, input logic [7:0] a, input logic [7:0] w,
                          input string nm);
    exp_t e;
    e.kind = kind; e.addr = addr; e.ea = a; e.ew = w;
    e.eca = '0; e.ecw = '0; e.efa = 1'b0; e.efw = 1'b0; e.name = nm;
    q.push_back(e);
  endtask

  // Wait (bounded) for the monitor to consume everything queued.
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks want 0", q.size());
      q.delete();
    end
  endtask

  // Present one write cycle; returns just after the capturing edge.
  task automatic wr(input bit ea, input logic [7:0] a, input bit ew, input logic [7:0] w);
    write_enable_A = ea; port_A = a;
    write_enable_W = ew; port_W = w;
    @(posedge clk);
    #1;
    write_enable_A = 1'b0;
    write_enable_W = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    port_A = '0; port_W = '0;
    write_enable_A = 1'b0; write_enable_W = 1'b0;
    rd_addr = '0;

    // Reset held two cycles: everything zero
    repeat (2) @(posedge clk);
    #1;
    push_cnt(0, 0, 0, 0, "reset_cnt");
    for (int i = 0; i < 16; i++) push_mem(K_MEM, i, 8'd0, 8'd0, "reset_mem");
    drain();
    rst = 1'b1;

    // Asynchronous pulse between edges clears a written entry immediately
    @(posedge clk); #1;
    wr(1'b1, 8'h33, 1'b1, 8'h44);
    push_cnt(1, 1, 0, 0, "pre_pulse_cnt");
    push_mem(K_MEM, 0, 8'h33, 8'h44, "pre_pulse_mem");
    drain();
    rst = 1'b0;
    #1;
    push_cnt(0, 0, 0, 0, "pulse_cnt");
    push_mem(K_MEM, 0, 8'd0, 8'd0, "pulse_mem");
    drain();
    rst = 1'b1;

    // Weight load
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 8'd0, 1'b1, wv[i]);
      if (i == 14) push_cnt(0, 15, 0, 0, "w15_cnt");
      drain();
    end
    push_cnt(0, 16, 0, 1, "w_full_cnt");
    for (int i = 0; i < 16; i++) push_mem(K_MEM, i, 8'd0, wv[i], "w_load_mem");
    drain();

    // Feature load
    for (int i = 0; i < 16; i++) wr(1'b1, 8'((i % 4) + 1), 1'b0, 8'd0);
    push_cnt(16, 16, 1, 1, "a_full_cnt");
    for (int i = 0; i < 16; i++) push_mem(K_MEM, i, 8'((i % 4) + 1), wv[i], "a_load_mem");
    drain();

    // Overflow write ignored on both channels
    wr(1'b1, 8'd9, 1'b1, 8'd9);
    push_cnt(16, 16, 1, 1, "ovf_cnt");
    push_mem(K_MEM, 0, 8'd1, 8'd4, "ovf_mem");
    drain();

    // Combinational readback sweep
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      push_mem(K_RD, i, 8'((i % 4) + 1), wv[i], "readback");
      drain();
    end

    // Concurrent writes with an idle gap
    rd_addr = '0;
    hold_reset();
    wr(1'b1, 8'd5, 1'b1, 8'd7);
    @(posedge clk); #1;
    wr(1'b1, 8'd6, 1'b1, 8'd8);
    push_cnt(2, 2, 0, 0, "conc_cnt");
    push_mem(K_MEM, 0, 8'd5, 8'd7, "conc_mem");
    push_mem(K_MEM, 1, 8'd6, 8'd8, "conc_mem");
    push_mem(K_MEM, 2, 8'd0, 8'd0, "conc_mem");
    drain();

    // Mid-load reset
    hold_reset();
    for (int i = 0; i < 6; i++) wr(1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h20 + i));
    push_cnt(6, 6, 0, 0, "mid_pre_cnt");
    drain();
    rst = 1'b0;
    #1;
    push_cnt(0, 0, 0, 0, "mid_rst_cnt");
    for (int i = 0; i < 6; i++) push_mem(K_MEM, i, 8'd0, 8'd0, "mid_rst_mem");
    drain();
    rst = 1'b1;
    @(posedge clk); #1;

    // Next write lands at index 0; same-cycle read still shows old value
    rd_addr = '0;
    write_enable_A = 1'b1; port_A = 8'hAA;
    push_mem(K_RD, 0, 8'h00, 8'h00, "rd_before_edge");
    drain();
    @(posedge clk); #1;
    write_enable_A = 1'b0;
    push_mem(K_RD, 0, 8'hAA, 8'h00, "rd_after_edge");
    push_cnt(1, 0, 0, 0, "post_rst_cnt");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
